// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, counter width and vertical state type used by
// the horizontal and vertical timing stages.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef enum logic [1:0] {
        VS_ACTIVE = 2'd0,
        VS_FRONT  = 2'd1,
        VS_SYNC   = 2'd2,
        VS_BACK   = 2'd3
    } vstate_t;

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector for the horizontal roll level. The history register
// resets high so a level already high at reset release is not seen as an edge.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic tick
);

    logic level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_q <= 1'b1;
        else     level_q <= level;
    end

    assign tick = level & ~level_q;

endmodule

// File: rtl/vcounter.sv
// Vertical timing stage: counts one line per roll rising edge and produces
// registered region flags, vsync, frame pulse and video_on. VGA_VSYNC_NEG_EN
// selects an active-low vsync (vde) output.
module vcounter
    import vga_timing_pkg::*;
#(
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF
) (
    input  logic             clkv,
    input  logic             clrv,
    input  logic             roll,
    output logic [CNT_W-1:0] cntrv,
    output logic             vd,
    output logic             vde,
    output logic             vdeb,
    output logic             vdebc,
    output logic             frame,
    output logic             video_on
);

    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (V_TOTAL > (1 << CNT_W)) begin : g_total_check
            $error("vcounter: V_TOTAL exceeds the 10-bit line counter range");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_LINE  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] FRONT_LINE = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LINE  = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] BACK_LINE  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

`ifdef VGA_VSYNC_NEG_EN
    localparam logic VDE_INV = 1'b1;
`else
    localparam logic VDE_INV = 1'b0;
`endif

    logic             line_tick;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    vstate_t          state_q, state_nxt;
    logic             vd_q, vde_q, vdeb_q, vdebc_q, frame_q;
    logic             vd_nxt, vde_nxt, vdeb_nxt, vdebc_nxt, frame_nxt;

    rise_det u_rise_det (
        .clk   (clkv),
        .rst   (clrv),
        .level (roll),
        .tick  (line_tick)
    );

    always_ff @(posedge clkv or posedge clrv) begin
        if (clrv) begin
            cnt_q   <= '0;
            state_q <= VS_ACTIVE;
            vd_q    <= 1'b0;
            vde_q   <= VDE_INV;
            vdeb_q  <= 1'b0;
            vdebc_q <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_nxt;
            state_q <= state_nxt;
            vd_q    <= vd_nxt;
            vde_q   <= vde_nxt;
            vdeb_q  <= vdeb_nxt;
            vdebc_q <= vdebc_nxt;
            frame_q <= frame_nxt;
        end
    end

    // Transitions look at the post-increment line number so flags and count move together.
    always_comb begin
        cnt_nxt   = cnt_q;
        state_nxt = state_q;
        frame_nxt = 1'b0;
        if (line_tick) begin
            if (cnt_q == LAST_LINE) begin
                cnt_nxt   = '0;
                frame_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
            case (state_q)
                VS_ACTIVE: if (cnt_nxt == FRONT_LINE) state_nxt = VS_FRONT;
                VS_FRONT:  if (cnt_nxt == SYNC_LINE)  state_nxt = VS_SYNC;
                VS_SYNC:   if (cnt_nxt == BACK_LINE)  state_nxt = VS_BACK;
                VS_BACK:   if (cnt_nxt == '0)         state_nxt = VS_ACTIVE;
                default:                              state_nxt = VS_ACTIVE;
            endcase
        end
        vdebc_nxt = (state_nxt == VS_ACTIVE);
        vd_nxt    = (state_nxt != VS_ACTIVE);
        vdeb_nxt  = (state_nxt == VS_BACK);
        vde_nxt   = (state_nxt == VS_SYNC) ^ VDE_INV;
    end

    assign cntrv    = cnt_q;
    assign vd       = vd_q;
    assign vde      = vde_q;
    assign vdeb     = vdeb_q;
    assign vdebc    = vdebc_q;
    assign frame    = frame_q;
    assign video_on = roll & vdebc_q;

endmodule
